servo_pwm_decoder: RTL and testbench



---
 rtl/servo_pwm_pkg.sv | 15 +
 rtl/pwm_edge_sync.sv | 61 ++++++
 rtl/servo_pwm_decoder.sv | 129 ++++++++++++
 tb/tb_servo_pwm_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pwm_pkg.sv
// Shared types and default timing constants for the servo PWM decoder.
package servo_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    localparam int TICK_DIV_50MHZ   = 50;
    localparam int SERVO_MIN_US     = 500;
    localparam int SERVO_MAX_US     = 2500;
    localparam int SERVO_TIMEOUT_US = 25000;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes the asynchronous PWM line and produces registered rise/fall pulses.
// Optional glitch filter enabled by defining PWM_GLITCH_FILTER_EN.
module pwm_edge_sync (
    input  logic clk_50MHz,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync2_q;
    logic src;
    logic level_q, rise_q, fall_q;

`ifdef PWM_GLITCH_FILTER_EN
    logic       filt_q;
    logic [1:0] stab_q;

    // The filtered level follows sync2 only after 4 consecutive differing samples.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b0;
            stab_q <= 2'd0;
        end else if (sync2_q == filt_q) begin
            stab_q <= 2'd0;
        end else if (stab_q == 2'd3) begin
            filt_q <= sync2_q;
            stab_q <= 2'd0;
        end else begin
            stab_q <= stab_q + 2'd1;
        end
    end

    assign src = filt_q;
`else
    assign src = sync2_q;
`endif

    // NOTE: non-blocking assignments keep the flop chain a true shift register.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            level_q <= src;
            rise_q  <= src & ~level_q;
            fall_q  <= ~src & level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures high time and period of a servo PWM line in microseconds.
// Build option PWM_GLITCH_FILTER_EN enables the input glitch filter in pwm_edge_sync.
module servo_pwm_decoder
    import servo_pwm_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_50MHZ,
    parameter int MIN_US     = SERVO_MIN_US,
    parameter int MAX_US     = SERVO_MAX_US,
    parameter int TIMEOUT_US = SERVO_TIMEOUT_US,
    parameter int CNT_W      = 16
) (
    input  logic             clk_50MHz,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] width_us,
    output logic [CNT_W-1:0] period_us,
    output logic             sample_valid,
    output logic             in_range,
    output logic             signal_lost
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_US);
    localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_US);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT_US);

    logic sync_level_unused;
    logic rise, fall;

    pwm_edge_sync u_edge_sync (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .level     (sync_level_unused),
        .rise      (rise),
        .fall      (fall)
    );

    state_e           state_q;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic [CNT_W-1:0] width_q, period_q;
    logic             valid_q, in_range_q, lost_q;
    logic             tick;
    logic             timeout;

    // NOTE: every always_comb output gets a value on every path, so no latches.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        hi_d    = (tick && hi_q   != CNT_MAX) ? hi_q   + 1'b1 : hi_q;
        per_d   = (tick && per_q  != CNT_MAX) ? per_q  + 1'b1 : per_q;
        idle_d  = (tick && idle_q != CNT_MAX) ? idle_q + 1'b1 : idle_q;
        timeout = (idle_q >= TIMEOUT_C);
    end

    // Edges take priority over the timeout, so a late edge still counts.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            hi_q       <= '0;
            per_q      <= '0;
            idle_q     <= '0;
            width_q    <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            lost_q     <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            presc_q <= presc_d;
            idle_q  <= idle_d;
            case (state_q)
                IDLE: begin
                    idle_q <= '0;
                    if (rise) begin
                        hi_q    <= '0;
                        per_q   <= '0;
                        presc_q <= '0;
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    hi_q  <= hi_d;
                    per_q <= per_d;
                    if (fall) begin
                        presc_q <= '0;
                        idle_q  <= '0;
                        state_q <= LOW;
                    end else if (timeout) begin
                        lost_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                LOW: begin
                    per_q <= per_d;
                    if (rise) begin
                        width_q    <= hi_q;
                        period_q   <= per_d;
                        in_range_q <= (hi_q >= MIN_C) && (hi_q <= MAX_C);
                        valid_q    <= 1'b1;
                        lost_q     <= 1'b0;
                        hi_q       <= '0;
                        per_q      <= '0;
                        presc_q    <= '0;
                        idle_q     <= '0;
                        state_q    <= HIGH;
                    end else if (timeout) begin
                        lost_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign width_us     = width_q;
    assign period_us    = period_q;
    assign sample_valid = valid_q;
    assign in_range     = in_range_q;
    assign signal_lost  = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Scoreboard bench for servo_pwm_decoder with a period-level reference model.
`timescale 1ns/1ps
module tb_servo_pwm_decoder;

    localparam int T   = 8;     // clock cycles per us in this bench
    localparam int MIN = 5;
    localparam int MAX = 25;
    localparam int TMO = 250;
    localparam int W   = 16;

    logic         clk_50MHz = 1'b0;
    logic         rst;
    logic         pwm_in;
    logic [W-1:0] width_us, period_us;
    logic         sample_valid, in_range, signal_lost;

    always #10 clk_50MHz = ~clk_50MHz;

    servo_pwm_decoder #(
        .TICK_DIV   (T),
        .MIN_US     (MIN),
        .MAX_US     (MAX),
        .TIMEOUT_US (TMO),
        .CNT_W      (W)
    ) dut (
        .clk_50MHz    (clk_50MHz),
        .rst          (rst),
        .pwm_in       (pwm_in),
        .width_us     (width_us),
        .period_us    (period_us),
        .sample_valid (sample_valid),
        .in_range     (in_range),
        .signal_lost  (signal_lost)
    );

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] p;
        logic        r;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: what the line looks like after filtering, in cycles.
    bit m_lvl   = 1'b0;
    bit m_armed = 1'b0;
    int m_hi    = 0;
    int m_lo    = 0;

    task automatic model_rise();
        exp_t e;
        int   w;
        if (m_armed) begin
            w   = m_hi / T;
            e.w = (w > 65535) ? 65535 : w;
            e.p = m_hi / T + m_lo / T;
            e.r = (w >= MIN) && (w <= MAX);
            sb_q.push_back(e);
        end
        m_armed = 1'b1;
        m_hi    = 0;
        m_lo    = 0;
    endtask

    // Drive one constant-level segment of cyc cycles and update the model.
    task automatic seg(input bit lvl, input int cyc);
        bit edge_seen;
        edge_seen = (lvl != m_lvl);
`ifdef PWM_GLITCH_FILTER_EN
        if (cyc < 4) edge_seen = 1'b0;
`endif
        if (edge_seen) begin
            m_lvl = lvl;
            if (lvl) model_rise();
        end
        if (m_lvl) m_hi += cyc;
        else       m_lo += cyc;
        pwm_in = lvl;
        repeat (cyc) @(negedge clk_50MHz);
    endtask

    task automatic period(input int hi_us, input int lo_us);
        seg(1'b1, hi_us * T);
        seg(1'b0, lo_us * T);
    endtask

    // Hold a level for 300 us starting with an edge; lost must rise near TMO us.
    task automatic hold_timeout(input bit lvl, input int keep_w);
        seg(lvl, (TMO - 10) * T);
        check("lost_before_timeout", signal_lost, 0);
        seg(lvl, 20 * T);
        check("lost_after_timeout", signal_lost, 1);
        seg(lvl, 40 * T);
        m_armed = 1'b0;
        check("width_kept_on_timeout", width_us, keep_w);
        check("sb_empty_on_timeout", sb_q.size(), 0);
    endtask

    // Monitor: every strobe pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_50MHz);
            if (rst === 1'b0 && sample_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: width %0d period %0d, expected no strobe",
                             width_us, period_us);
                end else begin
                    e = sb_q.pop_front();
                    check("strobe_width", width_us, e.w);
                    check("strobe_period", period_us, e.p);
                    check("strobe_in_range", in_range, e.r);
                    check("strobe_lost", signal_lost, 0);
                end
            end
        end
    end

    initial begin
        #5ms;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        check("rst_width", width_us, 0);
        check("rst_period", period_us, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_in_range", in_range, 0);
        check("rst_lost", signal_lost, 1);
        rst = 1'b0;
        seg(1'b0, 20 * T);

        // Nominal lock: 5 strobes from 6 rises.
        repeat (5) period(15, 85);
        seg(1'b1, 15 * T);
        check("nominal_width", width_us, 15);
        check("nominal_period", period_us, 100);
        check("nominal_in_range", in_range, 1);
        check("nominal_lost", signal_lost, 0);
        check("nominal_sb_empty", sb_q.size(), 0);
        seg(1'b0, 85 * T);

        // Out of range high and low.
        period(30, 70);
        period(4, 96);
        seg(1'b1, 15 * T);
        check("short_width", width_us, 4);
        check("short_in_range", in_range, 0);
        seg(1'b0, 85 * T);

        // Random periods, boundaries included.
        period(MIN, 80);
        period(MAX, 80);
        repeat (12) period($urandom_range(1, 40), $urandom_range(20, 150));
        seg(1'b1, 6);
        seg(1'b0, 50 * T + 1);
        period(15, 85);
        seg(1'b1, 15 * T);
        seg(1'b0, 85 * T);

        // Line stuck low after a locked pulse.
        period(15, 85);
        seg(1'b1, 15 * T);
        hold_timeout(1'b0, 15);
        period(15, 85);
        check("lost_until_relock", signal_lost, 1);
        period(15, 85);
        period(15, 85);
        check("relock_lost", signal_lost, 0);

        // Line stuck high from a fresh rise.
        hold_timeout(1'b1, 15);
        seg(1'b0, 50 * T);
        repeat (3) period(15, 85);

        // Reset mid high phase.
        seg(1'b1, 7 * T);
        rst = 1'b1;
        #1;
        check("midrst_width", width_us, 0);
        check("midrst_period", period_us, 0);
        check("midrst_valid", sample_valid, 0);
        check("midrst_in_range", in_range, 0);
        check("midrst_lost", signal_lost, 1);
        m_armed = 1'b0;
        m_lvl   = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        pwm_in = 1'b0;
        rst    = 1'b0;
        seg(1'b0, 30 * T);
        period(15, 85);
        check("postrst_lost", signal_lost, 1);
        period(15, 85);
        period(15, 85);

        // Short low glitches inside a 15 us pulse.
        seg(1'b1, 40);
        seg(1'b0, 2);
        seg(1'b1, 40);
        seg(1'b0, 2);
        seg(1'b1, 36);
        seg(1'b0, 85 * T);
        period(15, 85);
        seg(1'b1, 15 * T);
        seg(1'b0, 20 * T);

        repeat (50) @(negedge clk_50MHz);
        check("final_sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
